cpu_state_dump: RTL and testbench

Synthesizable, parametrised state-dump engine for the RISC-V FFT CPU. On `start` it walks the register file, a window of data memory, and the FFT output bins, and streams one tagged record per element over a valid/ready port. It replaces bench-side hierarchical peeking with an in-design debug/trace path usable on silicon and in simulation. It sits beside `cpu`, sharing the regfile and dmem debug read ports and the FFT flat output buses.

---
 rtl/cpu_state_dump_pkg.sv | 21 ++
 rtl/cpu_state_dump_if.sv | 31 +++
 rtl/cpu_state_dump_fft_bin_select.sv | 24 ++
 rtl/cpu_state_dump.sv | 178 +++++++++++++++++
 tb/tb_cpu_state_dump.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_state_dump_pkg.sv
// cpu_dump_pkg: shared definitions for the CPU state-dump engine.
//   - section tags carried on out_tag (REG, MEM, FFT)
//   - dump FSM state encoding
//   - width of the per-record element index field
package cpu_dump_pkg;

   localparam int IDX_W = 16;

   localparam logic [1:0] TAG_REG = 2'd0;
   localparam logic [1:0] TAG_MEM = 2'd1;
   localparam logic [1:0] TAG_FFT = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_CAPTURE,
      ST_EMIT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/cpu_state_dump_if.sv
// cpu_state_dump_if: record stream from the dump engine to its consumer.
//   out_valid  record available (producer)
//   out_ready  consumer accepts (consumer)
//   out_tag    section tag of the record
//   out_index  element index within its section
//   out_data   register/memory word, or packed FFT bin
//   out_last   final record of the dump
interface cpu_state_dump_if
   import cpu_dump_pkg::*;
#(
   parameter int XLEN = 32
) ();

   logic             out_valid;
   logic             out_ready;
   logic [1:0]       out_tag;
   logic [IDX_W-1:0] out_index;
   logic [XLEN-1:0]  out_data;
   logic             out_last;

   modport master (
      output out_valid, out_tag, out_index, out_data, out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_tag, out_index, out_data, out_last,
      output out_ready
   );

endinterface

// File: rtl/cpu_state_dump_fft_bin_select.sv
// fft_bin_select: combinational extract of FFT bin 'bin' from the flat
// real/imag output buses, packed as {zero pad, im, re} into an XLEN word.
// Samples are copied bit-for-bit; no sign extension into the pad.
//   re_flat, im_flat  bin k occupies [k*FFT_DATA_W +: FFT_DATA_W]
//   bin               bin number to select
//   word              packed record payload
module fft_bin_select #(
   parameter int XLEN       = 32,
   parameter int FFT_N      = 8,
   parameter int FFT_DATA_W = 16
) (
   input  logic [FFT_N*FFT_DATA_W-1:0] re_flat,
   input  logic [FFT_N*FFT_DATA_W-1:0] im_flat,
   input  logic [$clog2(FFT_N)-1:0]    bin,
   output logic [XLEN-1:0]             word
);

   always_comb begin
      word                               = '0;
      word[FFT_DATA_W-1:0]               = re_flat[bin*FFT_DATA_W +: FFT_DATA_W];
      word[2*FFT_DATA_W-1:FFT_DATA_W]    = im_flat[bin*FFT_DATA_W +: FFT_DATA_W];
   end

endmodule

// File: rtl/cpu_state_dump.sv
// cpu_state_dump: on start, walks the register file, a data-memory window
// and the FFT output bins, emitting one tagged record per element.
//   clk, reset          clock; asynchronous active-low reset
//   start, sect_mask    begin a dump of the selected sections (REG/MEM/FFT)
//   abort               cancel an in-progress dump (no done pulse)
//   rf_raddr/rf_rdata   regfile debug read port (data one cycle after addr)
//   dm_raddr/dm_rdata   dmem debug read port (data one cycle after addr)
//   fft_re_flat/im_flat FFT output bins
//   dump                record stream (master side)
//   busy, done          dump in progress; one-cycle completion pulse
module cpu_state_dump
   import cpu_dump_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int NREGS      = 32,
   parameter int DMEM_WORDS = 32,
   parameter int FFT_N      = 8,
   parameter int FFT_DATA_W = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [2:0]                    sect_mask,
   input  logic                          abort,
   output logic [$clog2(NREGS)-1:0]      rf_raddr,
   input  logic [XLEN-1:0]               rf_rdata,
   output logic [$clog2(DMEM_WORDS)-1:0] dm_raddr,
   input  logic [XLEN-1:0]               dm_rdata,
   input  logic [FFT_N*FFT_DATA_W-1:0]   fft_re_flat,
   input  logic [FFT_N*FFT_DATA_W-1:0]   fft_im_flat,
   cpu_state_dump_if.master              dump,
   output logic                          busy,
   output logic                          done
);

   localparam int RA_W = $clog2(NREGS);
   localparam int DA_W = $clog2(DMEM_WORDS);
   localparam int FI_W = $clog2(FFT_N);

   state_t           state, state_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic [1:0]       sect, sect_n;
   logic [2:0]       mask, mask_n;

   logic [XLEN-1:0]  fft_word, src;
   logic [XLEN-1:0]  data_q;
   logic [1:0]       tag_q;
   logic [IDX_W-1:0] index_q;
   logic             last_q;

   logic             sect_end;
   logic [2:0]       first_sect, next_sect;

   // Lowest enabled section at or above 'from'; result is {found, section}.
   function automatic logic [2:0] sect_from(input logic [2:0] m, input int from);
      logic [2:0] r;
      r = '0;
      for (int s = 2; s >= 0; s--) begin
         if (s >= from && m[s]) r = {1'b1, 2'(s)};
      end
      return r;
   endfunction

   function automatic logic [IDX_W-1:0] last_index(input logic [1:0] s);
      case (s)
         TAG_REG: return IDX_W'(NREGS - 1);
         TAG_MEM: return IDX_W'(DMEM_WORDS - 1);
         default: return IDX_W'(FFT_N - 1);
      endcase
   endfunction

   assign sect_end   = (idx == last_index(sect));
   assign first_sect = sect_from(sect_mask, 0);
   assign next_sect  = sect_from(mask, int'(sect) + 1);

   fft_bin_select #(
      .XLEN       (XLEN),
      .FFT_N      (FFT_N),
      .FFT_DATA_W (FFT_DATA_W)
   ) u_bin_select (
      .re_flat (fft_re_flat),
      .im_flat (fft_im_flat),
      .bin     (idx[FI_W-1:0]),
      .word    (fft_word)
   );

   // Debug read addresses are only driven while issuing; 0 otherwise.
   always_comb begin
      rf_raddr = '0;
      dm_raddr = '0;
      if (state == ST_ISSUE) begin
         if (sect == TAG_REG) rf_raddr = idx[RA_W-1:0];
         if (sect == TAG_MEM) dm_raddr = idx[DA_W-1:0];
      end
   end

   always_comb begin
      case (sect)
         TAG_REG: src = rf_rdata;
         TAG_MEM: src = dm_rdata;
         default: src = fft_word;
      endcase
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      sect_n  = sect;
      mask_n  = mask;
      case (state)
         ST_IDLE: begin
            if (start && !abort) begin
               mask_n = sect_mask;
               idx_n  = '0;
               if (first_sect[2]) begin
                  sect_n  = first_sect[1:0];
                  state_n = ST_ISSUE;
               end else begin
                  state_n = ST_DONE;
               end
            end
         end
         ST_ISSUE:   state_n = ST_CAPTURE;
         ST_CAPTURE: state_n = ST_EMIT;
         ST_EMIT: begin
            if (dump.out_ready) begin
               if (!sect_end) begin
                  idx_n   = idx + IDX_W'(1);
                  state_n = ST_ISSUE;
               end else if (next_sect[2]) begin
                  sect_n  = next_sect[1:0];
                  idx_n   = '0;
                  state_n = ST_ISSUE;
               end else begin
                  state_n = ST_DONE;
               end
            end
         end
         ST_DONE:    state_n = ST_IDLE;
         default:    state_n = ST_IDLE;
      endcase
      if (abort && state != ST_IDLE) state_n = ST_IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         idx     <= '0;
         sect    <= '0;
         mask    <= '0;
         data_q  <= '0;
         tag_q   <= '0;
         index_q <= '0;
         last_q  <= 1'b0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         sect  <= sect_n;
         mask  <= mask_n;
         // Record is frozen here; later source changes are not reflected.
         if (state == ST_CAPTURE) begin
            data_q  <= src;
            tag_q   <= sect;
            index_q <= idx;
            last_q  <= sect_end && !next_sect[2];
         end
      end
   end

   assign dump.out_valid = (state == ST_EMIT);
   assign dump.out_tag   = tag_q;
   assign dump.out_index = index_q;
   assign dump.out_data  = data_q;
   assign dump.out_last  = last_q;
   assign busy           = (state != ST_IDLE);
   assign done           = (state == ST_DONE);

endmodule

// File: tb/tb_cpu_state_dump.sv
// tb_cpu_state_dump: drives the dump engine from behavioural source memories
// and checks every record against an expected list built from the section
// walk order. A second instance uses NREGS=16, DMEM_WORDS=4, FFT_N=64.
module tb_cpu_state_dump;
   import cpu_dump_pkg::*;

   localparam int W = 16;
   typedef logic [50:0] rec_t;   // {tag, index, data, last}

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start, start2;
   logic [2:0]  sect_mask, sect_mask2;
   logic        abort, abort2;
   logic [4:0]  rf_raddr, dm_raddr;
   logic [3:0]  rf_raddr2;
   logic [1:0]  dm_raddr2;
   logic [31:0] rf_rdata, dm_rdata, rf_rdata2, dm_rdata2;
   logic [8*W-1:0]  re_flat, im_flat;
   logic [64*W-1:0] re_flat2, im_flat2;
   logic        busy, done, busy2, done2;

   logic [31:0] regs [32];
   logic [31:0] mem  [32];
   logic [15:0] fre  [64];
   logic [15:0] fim  [64];

   int total = 0;
   int bad   = 0;
   rec_t q[$];

   cpu_state_dump_if #(.XLEN(32)) dif ();
   cpu_state_dump_if #(.XLEN(32)) dif2 ();

   cpu_state_dump u_dut (
      .clk(clk), .reset(reset), .start(start), .sect_mask(sect_mask), .abort(abort),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dm_raddr(dm_raddr), .dm_rdata(dm_rdata),
      .fft_re_flat(re_flat), .fft_im_flat(im_flat), .dump(dif.master),
      .busy(busy), .done(done)
   );

   cpu_state_dump #(.NREGS(16), .DMEM_WORDS(4), .FFT_N(64)) u_dut2 (
      .clk(clk), .reset(reset), .start(start2), .sect_mask(sect_mask2), .abort(abort2),
      .rf_raddr(rf_raddr2), .rf_rdata(rf_rdata2), .dm_raddr(dm_raddr2), .dm_rdata(dm_rdata2),
      .fft_re_flat(re_flat2), .fft_im_flat(im_flat2), .dump(dif2.master),
      .busy(busy2), .done(done2)
   );

   // Synchronous-read debug ports: data one cycle after the address.
   always @(posedge clk) begin
      rf_rdata  <= regs[rf_raddr];
      dm_rdata  <= mem[dm_raddr];
      rf_rdata2 <= regs[rf_raddr2];
      dm_rdata2 <= mem[dm_raddr2];
   end

   always_comb begin
      re_flat = '0; im_flat = '0; re_flat2 = '0; im_flat2 = '0;
      for (int k = 0; k < 8; k++) begin
         re_flat[k*W +: W] = fre[k];
         im_flat[k*W +: W] = fim[k];
      end
      for (int k = 0; k < 64; k++) begin
         re_flat2[k*W +: W] = fre[k];
         im_flat2[k*W +: W] = fim[k];
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected records: enabled sections in REG, MEM, FFT order, each walked
   // from index 0; only the very last record carries last=1.
   task automatic build(input logic [2:0] m, input int nr, input int nm, input int nf);
      int   sz [3];
      rec_t t;
      sz = '{nr, nm, nf};
      q.delete();
      for (int s = 0; s < 3; s++) begin
         if (m[s]) begin
            for (int i = 0; i < sz[s]; i++) begin
               logic [31:0] d;
               if (s == 0)      d = regs[i];
               else if (s == 1) d = mem[i];
               else             d = {16'h0000, fim[i], fre[i]};
               q.push_back({2'(s), 16'(i), d, 1'b0});
            end
         end
      end
      if (q.size() > 0) begin
         t = q[q.size()-1];
         t[0] = 1'b1;
         q[q.size()-1] = t;
      end
   endtask

   function automatic rec_t cur_rec(input bit sel);
      if (sel) return {dif2.out_tag, dif2.out_index, dif2.out_data, dif2.out_last};
      return {dif.out_tag, dif.out_index, dif.out_data, dif.out_last};
   endfunction

   task automatic set_ready(input bit sel, input logic v);
      if (sel) dif2.out_ready = v;
      else     dif.out_ready  = v;
   endtask

   task automatic set_start(input bit sel, input logic v, input logic [2:0] m);
      if (sel) begin start2 = v; sect_mask2 = m; end
      else     begin start  = v; sect_mask  = m; end
   endtask

   task automatic randomize_srcs();
      for (int i = 0; i < 32; i++) begin
         regs[i] = $urandom;
         mem[i]  = $urandom;
      end
      for (int k = 0; k < 64; k++) begin
         fre[k] = 16'($urandom);
         fim[k] = 16'($urandom);
      end
   endtask

   // rmode: 0 ready always, 1 ready one cycle in four, 2 random ready.
   // With ready always high each record costs 3 cycles, so done is seen
   // 3*N+1 negedges after start was raised.
   task automatic run_dump(input bit sel, input logic [2:0] m, input int rmode, input bit hold);
      int   cyc, nrec;
      bit   seen_done, stalled, busy_ok;
      rec_t got, held;
      logic r, v, b, dn;
      if (sel) build(m, 16, 4, 64);
      else     build(m, 32, 32, 8);
      @(negedge clk);
      set_start(sel, 1'b1, m);
      cyc = 0; nrec = 0; seen_done = 0; stalled = 0; busy_ok = 1; held = '0;
      while (!seen_done && cyc < 6000) begin
         @(negedge clk);
         cyc++;
         if (!hold) set_start(sel, 1'b0, m);
         case (rmode)
            0:       r = 1'b1;
            1:       r = (cyc % 4 == 0);
            default: r = 1'($urandom_range(0, 1));
         endcase
         set_ready(sel, r);
         v  = sel ? dif2.out_valid : dif.out_valid;
         b  = sel ? busy2 : busy;
         dn = sel ? done2 : done;
         if (!b) busy_ok = 0;
         if (v) begin
            got = cur_rec(sel);
            if (stalled) chk("stall_hold", got, held);
            if (r) begin
               if (nrec < q.size()) chk($sformatf("rec%0d", nrec), got, q[nrec]);
               else                 chk("extra_record", nrec, q.size());
               nrec++;
               stalled = 0;
            end else begin
               held    = got;
               stalled = 1;
            end
         end
         if (dn) begin
            seen_done = 1;
            set_start(sel, 1'b0, m);
            chk("record_count", nrec, q.size());
            if (rmode == 0) chk("done_cycle", cyc, 3 * q.size() + 1);
         end
      end
      chk("done_seen", seen_done, 1);
      chk("busy_during_dump", busy_ok, 1);
      set_start(sel, 1'b0, m);
      @(negedge clk);
      if (sel) chk("idle_after2", {busy2, done2, dif2.out_valid}, 0);
      else     chk("idle_after", {busy, done, dif.out_valid}, 0);
   endtask

   initial begin
      int  n;
      bit  hit, saw_done;
      logic [2:0] rm;

      reset = 1'b0; start = 0; start2 = 0; sect_mask = 0; sect_mask2 = 0;
      abort = 0; abort2 = 0; dif.out_ready = 0; dif2.out_ready = 0;
      for (int i = 0; i < 32; i++) begin
         regs[i] = 32'(i * 32'h11);
         mem[i]  = 32'hA000_0000 + 32'(i);
      end
      for (int k = 0; k < 64; k++) begin
         fre[k] = 16'(k);
         fim[k] = 16'(-k);
      end
      #1;
      chk("reset_outputs", {dif.out_valid, dif.out_tag, dif.out_index, dif.out_data,
                            dif.out_last, busy, done, rf_raddr, dm_raddr}, 0);
      chk("reset_outputs2", {dif2.out_valid, dif2.out_data, busy2, done2, rf_raddr2, dm_raddr2}, 0);
      @(negedge clk); reset = 1'b1;
      @(negedge clk);

      // Full default dump with the reference pattern (FFT bin 3 = FFFD_0003).
      run_dump(0, 3'b111, 0, 0);
      chk("fft_bin3_model", q[67][32:1], 32'hFFFD_0003);

      // MEM only, heavily stalled, random contents.
      randomize_srcs();
      run_dump(0, 3'b010, 1, 0);

      // Empty mask: straight to done.
      run_dump(0, 3'b000, 0, 0);

      // Abort while REG index 5 is waiting in EMIT.
      @(negedge clk);
      dif.out_ready = 1'b0; start = 1'b1; sect_mask = 3'b111;
      hit = 0; n = 0;
      while (!hit && n < 200) begin
         @(negedge clk);
         start = 1'b0; n++;
         dif.out_ready = !(dif.out_valid && dif.out_tag == TAG_REG && dif.out_index == 16'd5);
         if (dif.out_valid && !dif.out_ready) hit = 1;
      end
      chk("abort_reached_idx5", hit, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_idle", {busy, dif.out_valid, done}, 0);
      saw_done = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done || busy) saw_done = 1;
      end
      chk("abort_no_done", saw_done, 0);

      // abort and start together in IDLE: abort wins.
      start = 1'b1; abort = 1'b1; sect_mask = 3'b111;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("abort_beats_start", busy, 0);
      run_dump(0, 3'b111, 2, 0);

      // Asynchronous reset in the middle of the MEM section.
      @(negedge clk);
      start = 1'b1; sect_mask = 3'b010; dif.out_ready = 1'b1;
      hit = 0; n = 0;
      while (!hit && n < 200) begin
         @(negedge clk);
         start = 1'b0; n++;
         if (dif.out_valid && dif.out_index == 16'd10) hit = 1;
      end
      chk("reset_reached_mem10", hit, 1);
      #2 reset = 1'b0;
      #1;
      chk("async_reset_zero", {dif.out_valid, dif.out_tag, dif.out_index, dif.out_data,
                               dif.out_last, busy, done, rf_raddr, dm_raddr}, 0);
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", busy, 0);

      // Random mask, random ready, start held high throughout the dump.
      randomize_srcs();
      rm = 3'($urandom_range(1, 7));
      run_dump(0, rm, 2, 1);

      // Alternate geometry: 16 + 4 + 64 records.
      run_dump(1, 3'b111, 0, 0);
      chk("dut2_last_fft_index", q[83][50:33], {TAG_FFT, 16'd63});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
